// File: rtl/pong_motion_ctrl.sv
// Pong game motion controller: a frame tick taken from the VGA scan position steps the paddle
// and ball once per frame, with ball bounces, misses, a serve delay and a lives count.
module pong_motion_ctrl #(
    parameter int PADDLE_H    = 72,
    parameter int BALL_SZ     = 8,
    parameter int PADDLE_STEP = 4,
    parameter int BALL_STEP   = 2,
    parameter int SERVE_WAIT  = 60
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       start,
    output logic [9:0] paddle_y,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic [1:0] lives,
    output logic       miss,
    output logic       game_over
);

    typedef enum logic [1:0] {S_IDLE, S_PLAY, S_MISS, S_OVER} state_t;

    localparam int CNT_W = (SERVE_WAIT > 1) ? $clog2(SERVE_WAIT) : 1;

    localparam logic [9:0]       SERVE_X   = 10'd316;
    localparam logic [9:0]       SERVE_Y   = 10'd236;
    localparam logic [9:0]       SERVE_PAD = 10'd204;
    localparam logic [10:0]      PAD_MAX   = 11'(480 - PADDLE_H);
    localparam logic [10:0]      X_LIM     = 11'd639;
    localparam logic [10:0]      Y_LIM     = 11'd479;
    localparam logic [10:0]      P_STEP    = 11'(PADDLE_STEP);
    localparam logic [10:0]      B_STEP    = 11'(BALL_STEP);
    localparam logic [10:0]      B_SZ      = 11'(BALL_SZ);
    localparam logic [10:0]      P_H       = 11'(PADDLE_H);
    localparam logic [10:0]      BOTTOM    = 11'(479 - BALL_STEP);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SERVE_WAIT - 1);

    state_t           state, state_n;
    logic [9:0]       paddle_n, ball_x_n, ball_y_n;
    logic             dx, dy, dx_n, dy_n;        // 1 = moving toward larger coordinate
    logic [1:0]       lives_n;
    logic             miss_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             tick_cond, tick_q, tick;

    // Wide copies of the current position so sums and differences cannot wrap.
    logic [10:0] pad_w, bx_w, by_w, pad_mv, bx_mv, by_mv;
    logic        hit;

    assign tick_cond = (pixel_x == 10'd0) && (pixel_y == 10'd481);
    assign tick      = tick_cond && !tick_q;
    assign game_over = (state == S_OVER);

    assign pad_w = {1'b0, paddle_y};
    assign bx_w  = {1'b0, ball_x};
    assign by_w  = {1'b0, ball_y};
    assign hit   = (bx_w + B_SZ >= 11'd600) && (bx_w + B_SZ <= 11'd603) &&
                   (by_w + B_SZ >= pad_w) && (by_w <= pad_w + P_H);

    // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
    always_comb begin
        state_n  = state;
        paddle_n = paddle_y;
        ball_x_n = ball_x;
        ball_y_n = ball_y;
        dx_n     = dx;
        dy_n     = dy;
        lives_n  = lives;
        cnt_n    = cnt;
        miss_n   = 1'b0;
        pad_mv   = pad_w;
        bx_mv    = bx_w;
        by_mv    = by_w;

        unique case (state)
            S_IDLE: begin
                paddle_n = SERVE_PAD;
                ball_x_n = SERVE_X;
                ball_y_n = SERVE_Y;
                dx_n     = 1'b1;
                dy_n     = 1'b1;
                if (start) state_n = S_PLAY;
            end
            S_PLAY: begin
                if (tick) begin
                    if (bx_w > 11'd631) begin
                        miss_n  = 1'b1;
                        lives_n = lives - 2'd1;
                        state_n = (lives != 2'd1) ? S_MISS : S_OVER;
                    end else begin
                        if (btn_up && !btn_down)
                            pad_mv = (pad_w < P_STEP) ? 11'd0 : pad_w - P_STEP;
                        else if (btn_down && !btn_up)
                            pad_mv = (pad_w + P_STEP > PAD_MAX) ? PAD_MAX : pad_w + P_STEP;

                        // Directions come from the pre-move position; each axis is independent.
                        if (bx_w <= 11'd36)        dx_n = 1'b1;
                        if (hit)                   dx_n = 1'b0;
                        if (by_w <= B_STEP)        dy_n = 1'b1;
                        if (by_w + B_SZ >= BOTTOM) dy_n = 1'b0;

                        if (dx_n) bx_mv = (bx_w + B_STEP > X_LIM) ? X_LIM : bx_w + B_STEP;
                        else      bx_mv = (bx_w < B_STEP) ? 11'd0 : bx_w - B_STEP;
                        if (dy_n) by_mv = (by_w + B_STEP > Y_LIM) ? Y_LIM : by_w + B_STEP;
                        else      by_mv = (by_w < B_STEP) ? 11'd0 : by_w - B_STEP;

                        paddle_n = pad_mv[9:0];
                        ball_x_n = bx_mv[9:0];
                        ball_y_n = by_mv[9:0];
                    end
                end
            end
            S_MISS: begin
                if (tick) begin
                    if (cnt == CNT_LAST) begin
                        cnt_n    = '0;
                        paddle_n = SERVE_PAD;
                        ball_x_n = SERVE_X;
                        ball_y_n = SERVE_Y;
                        dx_n     = 1'b1;
                        dy_n     = 1'b1;
                        state_n  = S_PLAY;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            S_OVER: begin
                if (start) begin
                    lives_n  = 2'd3;
                    paddle_n = SERVE_PAD;
                    ball_x_n = SERVE_X;
                    ball_y_n = SERVE_Y;
                    dx_n     = 1'b1;
                    dy_n     = 1'b1;
                    state_n  = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            paddle_y <= SERVE_PAD;
            ball_x   <= SERVE_X;
            ball_y   <= SERVE_Y;
            dx       <= 1'b1;
            dy       <= 1'b1;
            lives    <= 2'd3;
            miss     <= 1'b0;
            cnt      <= '0;
            tick_q   <= 1'b0;
        end else begin
            state    <= state_n;
            paddle_y <= paddle_n;
            ball_x   <= ball_x_n;
            ball_y   <= ball_y_n;
            dx       <= dx_n;
            dy       <= dy_n;
            lives    <= lives_n;
            miss     <= miss_n;
            cnt      <= cnt_n;
            tick_q   <= tick_cond;
        end
    end

endmodule
